// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and flush-pattern helper for elastic pipeline stages
package pipe_pkg;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} stage_state_t;

   localparam logic [31:0] DEBUG_PATTERN = 32'h2A2A_2A2A;
   localparam int FILL_MAX = 1024;

   // Each lane gets the pattern truncated or zero-extended to the lane width
   function automatic logic [FILL_MAX-1:0] pattern_fill(input int unsigned width,
                                                        input int unsigned lanes,
                                                        input logic [31:0] pat = DEBUG_PATTERN);
      logic [FILL_MAX-1:0] lane;
      logic [FILL_MAX-1:0] r;
      lane = FILL_MAX'(pat) & ((FILL_MAX'(1) << width) - FILL_MAX'(1));
      r = '0;
      for (int unsigned l = 0; l < lanes; l++) r |= lane << (l * width);
      return r;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one stage entry; clear has priority and refills data with the debug pattern
module pipe_slot #(
   parameter int W = 32,
   parameter int SIDE_W = 1,
   parameter logic [W-1:0] FILL = '0
) (
   input  logic              clk,
   input  logic              load,
   input  logic              clear,
   input  logic [W-1:0]      in_data,
   input  logic [SIDE_W-1:0] in_side,
   output logic              valid,
   output logic [W-1:0]      data,
   output logic [SIDE_W-1:0] side
);

   always_ff @(posedge clk) begin
      if (clear) begin
         valid <= 1'b0;
         data  <= FILL;
         side  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         side  <= in_side;
      end
   end

endmodule

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: handshaked pipeline register with flush, stall and optional skid entry
module elastic_pipe_stage import pipe_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int LANES = 3,
   parameter int SIDE_W = 1,
   parameter int SKID = 1,
   parameter logic [31:0] FLUSH_PATTERN = DEBUG_PATTERN
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    In_Valid,
   output logic                    In_Ready,
   input  logic [LANES*DATA_W-1:0] In_Data,
   input  logic [SIDE_W-1:0]       In_Side,
   input  logic                    Flush,
   input  logic                    Stall_En,
   output logic                    Out_Valid,
   input  logic                    Out_Ready,
   output logic [LANES*DATA_W-1:0] Out_Data,
   output logic [SIDE_W-1:0]       Out_Side,
   output logic [1:0]              Occupancy
);

   localparam int W = LANES * DATA_W;
   localparam logic [FILL_MAX-1:0] FILL_ALL = pattern_fill(DATA_W, LANES, FLUSH_PATTERN);
   localparam logic [W-1:0] FILL = FILL_ALL[W-1:0];

   stage_state_t      state;
   logic              kill, in_xfer, out_xfer;
   logic              head_valid, head_load, head_clear, skid_valid;
   logic [W-1:0]      skid_data, head_din;
   logic [SIDE_W-1:0] skid_side, head_sin;

   assign kill     = RST || Flush;
   assign in_xfer  = In_Valid && In_Ready;
   assign out_xfer = head_valid && Out_Ready && !Stall_En;

   // When FULL the skid entry refills the head, preserving FIFO order
   assign head_load  = (in_xfer && (state == ST_EMPTY || out_xfer)) || (state == ST_FULL && out_xfer);
   assign head_clear = kill || (state == ST_ONE && out_xfer && !in_xfer);
   assign head_din   = state == ST_FULL ? skid_data : In_Data;
   assign head_sin   = state == ST_FULL ? skid_side : In_Side;

   pipe_slot #(.W(W), .SIDE_W(SIDE_W), .FILL(FILL)) u_head (
      .clk(CLK), .load(head_load), .clear(head_clear), .in_data(head_din), .in_side(head_sin),
      .valid(head_valid), .data(Out_Data), .side(Out_Side)
   );

   assign Out_Valid = head_valid;
   assign Occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

   generate
      if (SKID != 0) begin : g_skid
         logic skid_load, skid_clear;
         assign skid_load  = in_xfer && state == ST_ONE && !out_xfer;
         assign skid_clear = kill || (state == ST_FULL && out_xfer);
         pipe_slot #(.W(W), .SIDE_W(SIDE_W), .FILL(FILL)) u_skid (
            .clk(CLK), .load(skid_load), .clear(skid_clear), .in_data(In_Data), .in_side(In_Side),
            .valid(skid_valid), .data(skid_data), .side(skid_side)
         );
         always_ff @(posedge CLK) begin
            if (kill) begin
               state    <= ST_EMPTY;
               In_Ready <= 1'b1;
            end else begin
               case (state)
                  ST_EMPTY: if (in_xfer) state <= ST_ONE;
                  ST_ONE: begin
                     if (in_xfer && !out_xfer) begin
                        state    <= ST_FULL;
                        In_Ready <= 1'b0;
                     end else if (!in_xfer && out_xfer) state <= ST_EMPTY;
                  end
                  ST_FULL: begin
                     if (out_xfer) begin
                        state    <= ST_ONE;
                        In_Ready <= 1'b1;
                     end
                  end
                  default: begin
                     state    <= ST_EMPTY;
                     In_Ready <= 1'b1;
                  end
               endcase
            end
         end
      end else begin : g_single
         assign skid_valid = 1'b0;
         assign skid_data  = FILL;
         assign skid_side  = '0;
         assign state      = head_valid ? ST_ONE : ST_EMPTY;
         assign In_Ready   = !head_valid || (Out_Ready && !Stall_En);
      end
   endgenerate

   a_no_fill_when_full: assert property (@(posedge CLK) disable iff (RST) !(in_xfer && state == ST_FULL));
   a_hold_stable: assert property (@(posedge CLK)
      (Out_Valid && !(Out_Ready && !Stall_En) && !kill) |=> $stable(Out_Data));

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// tb_elastic_pipe_stage: directed + random scoreboard bench driving a SKID=1 and a SKID=0 stage in parallel
module tb_elastic_pipe_stage;

   localparam int DW = 32;
   localparam int L = 3;
   localparam int SW = 1;
   localparam int W = L * DW;
   localparam logic [W-1:0] FILL = {L{32'h2A2A_2A2A}};

   typedef struct packed {
      logic [W-1:0]  d;
      logic [SW-1:0] s;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst, in_valid, flush, stall, out_ready;
   logic [W-1:0]  in_data;
   logic [SW-1:0] in_side;
   logic          in_ready1, out_valid1, in_ready0, out_valid0;
   logic [W-1:0]  out_data1, out_data0;
   logic [SW-1:0] out_side1, out_side0;
   logic [1:0]    occ1, occ0;

   ent_t q1[$];
   ent_t q0[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   elastic_pipe_stage #(.DATA_W(DW), .LANES(L), .SIDE_W(SW), .SKID(1)) dut1 (
      .CLK(clk), .RST(rst), .In_Valid(in_valid), .In_Ready(in_ready1), .In_Data(in_data),
      .In_Side(in_side), .Flush(flush), .Stall_En(stall), .Out_Valid(out_valid1),
      .Out_Ready(out_ready), .Out_Data(out_data1), .Out_Side(out_side1), .Occupancy(occ1)
   );

   elastic_pipe_stage #(.DATA_W(DW), .LANES(L), .SIDE_W(SW), .SKID(0)) dut0 (
      .CLK(clk), .RST(rst), .In_Valid(in_valid), .In_Ready(in_ready0), .In_Data(in_data),
      .In_Side(in_side), .Flush(flush), .Stall_En(stall), .Out_Valid(out_valid0),
      .Out_Ready(out_ready), .Out_Data(out_data0), .Out_Side(out_side0), .Occupancy(occ0)
   );

   function automatic logic [W-1:0] mk(input logic [31:0] b);
      return {b + 32'd2, b + 32'd1, b};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, inout ent_t q[$], input logic [W-1:0] d, input logic [SW-1:0] s);
      ent_t e;
      tests++;
      assert (q.size() > 0) else begin
         fails++;
         $error("FAIL %s_underflow: observed output with %0d queued, expected at least 1", tag, q.size());
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({tag, "_data"}, d, e.d);
         chk({tag, "_side"}, W'(s), W'(e.s));
      end
   endtask

   // Invariants checked after every edge, inputs not yet changed
   task automatic inv();
      chk("occ1", W'(occ1), W'(q1.size()));
      chk("valid1", W'(out_valid1), W'(q1.size() != 0));
      chk("rdy1", W'(in_ready1), W'(q1.size() < 2));
      chk("occ0", W'(occ0), W'(q0.size()));
      chk("rdy0", W'(in_ready0), W'(q0.size() == 0 || (out_ready && !stall)));
      if (q1.size() == 0) begin
         chk("empty1_data", out_data1, FILL);
         chk("empty1_side", W'(out_side1), '0);
      end
      if (q0.size() == 0) chk("empty0_data", out_data0, FILL);
   endtask

   task automatic cyc();
      #1;
      if (rst || flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (in_valid && in_ready1) q1.push_back({in_data, in_side});
         if (in_valid && in_ready0) q0.push_back({in_data, in_side});
         if (out_valid1 && out_ready && !stall) pop_chk("out1", q1, out_data1, out_side1);
         if (out_valid0 && out_ready && !stall) pop_chk("out0", q0, out_data0, out_side0);
      end
      @(posedge clk);
      @(negedge clk);
      inv();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
      in_data = '0; in_side = '0;
      cyc();
      rst = 1'b0;
      chk("rst_rdy1", W'(in_ready1), W'(1'b1));
      chk("rst_data1", out_data1, FILL);
      // stream with Out_Ready=1
      in_valid = 1'b1; out_ready = 1'b1; in_data = {32'h1004, 32'h1000, 32'h13}; in_side = 1'b1;
      cyc();
      chk("t1_data", out_data1, {32'h1004, 32'h1000, 32'h13});
      chk("t1_side", W'(out_side1), W'(1'b1));
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t1_occ", W'(occ1), W'(2'd1));
      end
      in_valid = 1'b0;
      cyc();
      // backpressure fill
      out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h100); in_side = 1'b0;
      cyc();
      chk("t2_occA", W'(occ1), W'(2'd1));
      in_data = mk(32'h200); in_side = 1'b1;
      cyc();
      chk("t2_occB", W'(occ1), W'(2'd2));
      chk("t2_rdy", W'(in_ready1), '0);
      in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      chk("t2_rdy_after", W'(in_ready1), W'(1'b1));
      chk("t2_headB", out_data1, mk(32'h200));
      cyc();
      // stall hold while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h100); in_side = 1'b0;
      cyc();
      in_data = mk(32'h200);
      cyc();
      in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t3_hold", out_data1, mk(32'h100));
         chk("t3_occ", W'(occ1), W'(2'd2));
      end
      stall = 1'b0;
      cyc();
      chk("t3_release", out_data1, mk(32'h200));
      // flush beats stall and a pending input
      out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h300); in_side = 1'b1;
      cyc();
      chk("t4_full", W'(occ1), W'(2'd2));
      stall = 1'b1; flush = 1'b1; in_data = mk(32'h400);
      cyc();
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      chk("t4_valid", W'(out_valid1), '0);
      chk("t4_occ", W'(occ1), '0);
      chk("t4_data", out_data1, FILL);
      chk("t4_side", W'(out_side1), '0);
      chk("t4_rdy", W'(in_ready1), W'(1'b1));
      out_ready = 1'b1;
      cyc();
      chk("t4_absent", W'(out_valid1), '0);
      // single-slot replace in one edge
      out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h100); in_side = 1'b0;
      cyc();
      out_ready = 1'b1; in_data = mk(32'h300); in_side = 1'b1;
      #1;
      chk("t5_rdy0", W'(in_ready0), W'(1'b1));
      cyc();
      chk("t5_data0", out_data0, mk(32'h300));
      chk("t5_occ0", W'(occ0), W'(2'd1));
      // reset while FULL with input offered
      out_ready = 1'b0; in_data = mk(32'h500);
      cyc();
      chk("t6_full", W'(occ1), W'(2'd2));
      rst = 1'b1; in_data = mk(32'h600);
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      chk("t6_valid", W'(out_valid1), '0);
      chk("t6_occ", W'(occ1), '0);
      chk("t6_data", out_data1, FILL);
      chk("t6_side", W'(out_side1), '0);
      chk("t6_rdy", W'(in_ready1), W'(1'b1));
      chk("t6_occ0", W'(occ0), '0);
      // random traffic
      for (int i = 0; i < 300; i++) begin
         in_valid = $urandom_range(0, 1) == 1;
         out_ready = $urandom_range(0, 2) != 0;
         stall = $urandom_range(0, 3) == 0;
         flush = $urandom_range(0, 31) == 0;
         in_data = {$urandom, $urandom, $urandom};
         in_side = SW'($urandom_range(0, 1));
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
